// File: rtl/lifo_pkg.sv
// Shared constants and helpers for the lifo_flags stack block.
package lifo_pkg;

   localparam int unsigned LIFO_DWIDTH_DEF = 8;
   localparam int unsigned LIFO_AWIDTH_DEF = 3;

   // Number of words addressable with awidth address bits.
   function automatic int unsigned lifo_depth(input int unsigned awidth);
      return 32'(1) << awidth;
   endfunction

endpackage

// File: rtl/lifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// A read and a write to the same address in one cycle returns the old word.
module lifo_ram
   import lifo_pkg::*;
#(
   parameter int unsigned DWIDTH = LIFO_DWIDTH_DEF,
   parameter int unsigned AWIDTH = LIFO_AWIDTH_DEF
) (
   input  logic              clk_i,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AWIDTH-1:0] rd_addr,
   output logic [DWIDTH-1:0] rd_data
);

   localparam int unsigned DEPTH = lifo_depth(AWIDTH);

   logic [DWIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/lifo_flags.sv
// Single-clock LIFO with registered usedw and almost-full/almost-empty flags.
// Define LIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs ovf_o/udf_o.
module lifo_flags
   import lifo_pkg::*;
#(
   parameter int unsigned DWIDTH       = LIFO_DWIDTH_DEF,
   parameter int unsigned AWIDTH       = LIFO_AWIDTH_DEF,
   parameter int unsigned ALMOST_FULL  = 6,
   parameter int unsigned ALMOST_EMPTY = 2
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              wrreq_i,
   input  logic              rdreq_i,
   input  logic [DWIDTH-1:0] data_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              almost_empty_o,
   output logic              almost_full_o,
   output logic [AWIDTH:0]   usedw_o
`ifdef LIFO_ERR_FLAGS_EN
   ,
   output logic              ovf_o,
   output logic              udf_o
`endif
);

   localparam int unsigned DEPTH = lifo_depth(AWIDTH);
   localparam int unsigned UW    = AWIDTH + 1;

   localparam logic [AWIDTH:0] DEPTH_W = UW'(DEPTH);
   localparam logic [AWIDTH:0] AF_W    = UW'(ALMOST_FULL);
   localparam logic [AWIDTH:0] AE_W    = UW'(ALMOST_EMPTY);

   if (DWIDTH == 0 || AWIDTH == 0 || ALMOST_FULL > DEPTH || ALMOST_EMPTY >= DEPTH)
   begin : g_param_check
      $error("lifo_flags: parameter out of range");
   end

   logic [AWIDTH:0]   sp_q;
   logic [AWIDTH:0]   sp_d;
   logic              push_ok;
   logic              pop_ok;
   logic              ram_we;
   logic [AWIDTH-1:0] ram_waddr;
   logic [AWIDTH-1:0] ram_raddr;
   logic [DWIDTH-1:0] ram_q;
   logic              q_zero;

   // Accept/replace decode; a push paired with an accepted pop replaces the top, even when full.
   always_comb begin
      pop_ok    = rdreq_i && !empty_o;
      push_ok   = wrreq_i && (!full_o || pop_ok);
      sp_d      = sp_q;
      ram_we    = push_ok;
      ram_waddr = sp_q[AWIDTH-1:0];
      ram_raddr = AWIDTH'(sp_q - 1'b1);
      if (push_ok && pop_ok) begin
         ram_waddr = AWIDTH'(sp_q - 1'b1);
      end else if (push_ok) begin
         sp_d = sp_q + 1'b1;
      end else if (pop_ok) begin
         sp_d = sp_q - 1'b1;
      end
   end

   // Pointer and flags, all derived from the post-edge pointer.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         sp_q           <= '0;
         empty_o        <= 1'b1;
         full_o         <= 1'b0;
         almost_empty_o <= 1'b1;
         almost_full_o  <= (AF_W == '0);
         q_zero         <= 1'b1;
      end else begin
         sp_q           <= sp_d;
         empty_o        <= (sp_d == '0);
         full_o         <= (sp_d == DEPTH_W);
         almost_empty_o <= (sp_d <= AE_W);
         almost_full_o  <= (sp_d >= AF_W);
         if (pop_ok) begin
            q_zero <= 1'b0;
         end
      end
   end

   assign usedw_o = sp_q;

   // RAM read register is not reset; mask it until the first pop after reset.
   assign q_o = q_zero ? '0 : ram_q;

   lifo_ram #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
   ) u_ram (
      .clk_i   (clk_i),
      .wr_en   (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (data_i),
      .rd_en   (pop_ok),
      .rd_addr (ram_raddr),
      .rd_data (ram_q)
   );

`ifdef LIFO_ERR_FLAGS_EN
   // Sticky error flags for rejected lone pushes/pops.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         ovf_o <= 1'b0;
         udf_o <= 1'b0;
      end else begin
         if (wrreq_i && full_o && !rdreq_i) begin
            ovf_o <= 1'b1;
         end
         if (rdreq_i && empty_o && !wrreq_i) begin
            udf_o <= 1'b1;
         end
      end
   end
`endif

endmodule
